// File: rtl/uart_tx_ctrl_if.sv
// Byte handshake and shifter strobe bundle between the TX byte source, the
// controller and the TX shift register.
interface uart_tx_ctrl_if #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DIV_W = 16
);
  logic             i_valid;
  logic [DW-1:0]    i_data;
  logic [DIV_W-1:0] i_div;
  logic             o_ready;
  logic [DW-1:0]    o_data;
  logic             o_load;
  logic             o_ena;
  logic             o_busy;
  logic             o_done;

  // Byte source side: offers bytes, observes controller status and strobes
  modport master (
    output i_valid, i_data, i_div,
    input  o_ready, o_data, o_load, o_ena, o_busy, o_done
  );

  // Controller side
  modport slave (
    input  i_valid, i_data, i_div,
    output o_ready, o_data, o_load, o_ena, o_busy, o_done
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART TX sequencer: accepts a byte, strobes the shifter load once, then one
// shift-enable per bit period, holds the stop level, and pulses done.
module uart_tx_ctrl #(
  parameter int unsigned DW        = 8,
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic         clk,
  input  logic         rst,
  uart_tx_ctrl_if.slave ctrl
);

  localparam int unsigned BIT_W    = $clog2(DW + 3);
  localparam int unsigned LAST_BIT = DW + 1;
  localparam int unsigned BIT_MAX  = DW + 2;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STOP} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             stop_q, stop_d;
  logic [DW-1:0]    data_q, data_d;
  logic             ready_q, ready_d;
  logic             load_q, load_d;
  logic             ena_q, ena_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             baud_last;

  assign baud_last = (baud_q == div_q - DIV_W'(1));

  // State, counter and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      div_q   <= DIV_W'(1);
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      data_q  <= '0;
      ready_q <= 1'b1;
      load_q  <= 1'b0;
      ena_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      load_q  <= load_d;
      ena_q   <= ena_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state: leave SHIFT after the last enable, leave STOP after the stop time
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (ctrl.i_valid && ready_q) state_d = LOAD;
      LOAD:  state_d = SHIFT;
      SHIFT: if (ena_q && (bit_q == BIT_W'(LAST_BIT))) state_d = STOP;
      STOP:  if (baud_last && (stop_q == 1'(STOP_BITS - 1))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters, latched byte/divisor and registered strobes for the next cycle
  always_comb begin
    div_d  = div_q;
    data_d = data_q;
    baud_d = baud_q;
    bit_d  = bit_q;
    stop_d = stop_q;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        stop_d = 1'b0;
        if (state_d == LOAD) begin
          data_d = ctrl.i_data;
          div_d  = (ctrl.i_div == '0) ? DIV_W'(1) : ctrl.i_div;
        end
      end
      LOAD: begin
        baud_d = '0;
        bit_d  = '0;
      end
      SHIFT: begin
        if (state_d == STOP) begin
          baud_d = '0;
          stop_d = 1'b0;
        end else begin
          baud_d = baud_last ? '0 : baud_q + 1'b1;
        end
        if (ena_q && (bit_q != BIT_W'(BIT_MAX))) bit_d = bit_q + 1'b1;
      end
      STOP: begin
        baud_d = baud_last ? '0 : baud_q + 1'b1;
        if (baud_last) stop_d = stop_q + 1'b1;
      end
      default: ;
    endcase
    ready_d = (state_d == IDLE);
    load_d  = (state_d == LOAD);
    ena_d   = (state_d == SHIFT) && (baud_d == '0);
    busy_d  = (state_d != IDLE);
    done_d  = (state_q == STOP) && (state_d == IDLE);
  end

  assign ctrl.o_ready = ready_q;
  assign ctrl.o_data  = data_q;
  assign ctrl.o_load  = load_q;
  assign ctrl.o_ena   = ena_q;
  assign ctrl.o_busy  = busy_q;
  assign ctrl.o_done  = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: two controllers (1 and 2 stop bits), each driving a
// shift-register model; frame timing and serial line checked against
// hand-computed offsets from the load strobe.
module tb_uart_tx_ctrl;

  localparam int unsigned DW    = 8;
  localparam int unsigned DIV_W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_ctrl_if #(.DW(DW), .DIV_W(DIV_W)) bus1 ();
  uart_tx_ctrl_if #(.DW(DW), .DIV_W(DIV_W)) bus2 ();

  uart_tx_ctrl #(.DW(DW), .DIV_W(DIV_W), .STOP_BITS(1)) dut1 (.clk(clk), .rst(rst), .ctrl(bus1));
  uart_tx_ctrl #(.DW(DW), .DIV_W(DIV_W), .STOP_BITS(2)) dut2 (.clk(clk), .rst(rst), .ctrl(bus2));

  logic        tb_valid;
  logic [7:0]  tb_data;
  logic [15:0] tb_div;
  logic        sel;

  assign bus1.i_valid = tb_valid & ~sel;
  assign bus2.i_valid = tb_valid & sel;
  assign bus1.i_data  = tb_data;
  assign bus2.i_data  = tb_data;
  assign bus1.i_div   = tb_div;
  assign bus2.i_div   = tb_div;

  // Shift-register models: {data, start=0, idle=1}, shift right, fill with 1
  logic [9:0] sh1, sh2;
  always @(posedge clk or negedge rst) begin
    if (!rst) sh1 <= '1;
    else if (bus1.o_load) sh1 <= {bus1.o_data, 1'b0, 1'b1};
    else if (bus1.o_ena) sh1 <= {1'b1, sh1[9:1]};
  end
  always @(posedge clk or negedge rst) begin
    if (!rst) sh2 <= '1;
    else if (bus2.o_load) sh2 <= {bus2.o_data, 1'b0, 1'b1};
    else if (bus2.o_ena) sh2 <= {1'b1, sh2[9:1]};
  end

  logic m_load, m_ena, m_done, m_busy, m_ready, m_line;
  assign m_load  = sel ? bus2.o_load  : bus1.o_load;
  assign m_ena   = sel ? bus2.o_ena   : bus1.o_ena;
  assign m_done  = sel ? bus2.o_done  : bus1.o_done;
  assign m_busy  = sel ? bus2.o_busy  : bus1.o_busy;
  assign m_ready = sel ? bus2.o_ready : bus1.o_ready;
  assign m_line  = sel ? sh2[0] : sh1[0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   load_cyc = 0, done_cyc = 0, ena_first = 0, ena_last = 0;
  int   ena_n = 0, done_n = 0, overlap_n = 0, stray_n = 0;
  logic line_at [0:8191];

  // Event monitor on the selected controller, sampled mid-cycle
  always @(negedge clk) begin
    line_at[13'(cyc)] <= m_line;
    if (m_load) load_cyc <= cyc;
    if (m_load) ena_n <= 0;
    else if (m_ena) ena_n <= ena_n + 1;
    if (m_ena && ena_n == 0) ena_first <= cyc;
    if (m_ena) ena_last <= cyc;
    if (m_done) begin
      done_cyc <= cyc;
      done_n   <= done_n + 1;
    end
    if (m_load && m_ena) overlap_n <= overlap_n + 1;
    if (m_ena && !m_busy) stray_n <= stray_n + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_load(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (m_load) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, " load seen"}, int'(ok), 1);
  endtask

  task automatic wait_done(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (m_done) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, " done seen"}, int'(ok), 1);
    @(negedge clk); #1;
  endtask

  task automatic send(input string name, input logic s, input logic [7:0] d, input logic [15:0] dv);
    sel      = s;
    tb_data  = d;
    tb_div   = dv;
    tb_valid = 1'b1;
    wait_load(name);
    tb_valid = 1'b0;
    wait_done(name);
  endtask

  task automatic check_frame(input string name, input logic [7:0] d, input int dv,
                             input int exp_done, input int exp_last);
    int   de   = (dv == 0) ? 1 : dv;
    int   mism = 0;
    int   j;
    logic exp_bit;
    chk({name, " done offset"}, done_cyc - load_cyc, exp_done);
    chk({name, " ena count"}, ena_n, 10);
    chk({name, " first ena"}, ena_first - load_cyc, 1);
    chk({name, " last ena"}, ena_last - load_cyc, exp_last);
    if (line_at[13'(load_cyc + 1)] !== 1'b1) mism++;
    for (int c = load_cyc + 2; c < load_cyc + exp_done; c++) begin
      j = (c - load_cyc - 2) / de;
      if (j == 0) exp_bit = 1'b0;
      else if (j <= 8) exp_bit = d[j-1];
      else exp_bit = 1'b1;
      if (line_at[13'(c)] !== exp_bit) mism++;
    end
    chk({name, " line bad cycles"}, mism, 0);
  endtask

  typedef struct {
    logic        sel;
    logic [7:0]  data;
    logic [15:0] div;
    int          exp_done;
    int          exp_last;
  } vec_t;

  vec_t vecs [8];
  int   d1, dn;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 8'hA5, 16'd4, 42, 37};
    vecs[1] = '{1'b0, 8'h3C, 16'd1, 12, 10};
    vecs[2] = '{1'b0, 8'h81, 16'd0, 12, 10};
    vecs[3] = '{1'b0, 8'h5A, 16'd3, 32, 28};
    vecs[4] = '{1'b0, 8'hFF, 16'd2, 22, 19};
    vecs[5] = '{1'b1, 8'hFF, 16'd4, 46, 37};
    vecs[6] = '{1'b1, 8'h00, 16'd4, 46, 37};
    vecs[7] = '{1'b1, 8'h6E, 16'd1, 13, 10};

    tb_valid = 1'b0;
    tb_data  = 8'h00;
    tb_div   = 16'd4;
    sel      = 1'b0;
    rst      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset status 1", int'({bus1.o_ready, bus1.o_load, bus1.o_ena, bus1.o_busy, bus1.o_done}), 16);
    chk("reset data 1", int'(bus1.o_data), 0);
    chk("reset status 2", int'({bus2.o_ready, bus2.o_load, bus2.o_ena, bus2.o_busy, bus2.o_done}), 16);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single frames over a range of divisors, data and stop lengths
    for (int i = 0; i < 8; i++) begin
      send($sformatf("vec%0d", i), vecs[i].sel, vecs[i].data, vecs[i].div);
      check_frame($sformatf("vec%0d", i), vecs[i].data, int'(vecs[i].div),
                  vecs[i].exp_done, vecs[i].exp_last);
      repeat (2) @(posedge clk);
      #1;
    end

    // Back-to-back: valid held, second byte accepted on the done cycle
    sel      = 1'b0;
    tb_div   = 16'd4;
    tb_data  = 8'h3C;
    tb_valid = 1'b1;
    wait_load("b2b first");
    tb_data = 8'hC3;
    wait_done("b2b first");
    check_frame("b2b first", 8'h3C, 4, 42, 37);
    d1 = done_cyc;
    wait_load("b2b second");
    tb_valid = 1'b0;
    @(negedge clk); #1;
    chk("b2b load after done", load_cyc - d1, 1);
    wait_done("b2b second");
    check_frame("b2b second", 8'hC3, 4, 42, 37);
    repeat (2) @(posedge clk);
    #1;

    // Divisor and data changed mid-frame only affect the next frame
    tb_data  = 8'h96;
    tb_div   = 16'd4;
    tb_valid = 1'b1;
    wait_load("divchg a");
    tb_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    tb_div  = 16'd9;
    tb_data = 8'h00;
    wait_done("divchg a");
    check_frame("divchg a", 8'h96, 4, 42, 37);
    send("divchg b", 1'b0, 8'h4B, 16'd9);
    check_frame("divchg b", 8'h4B, 9, 92, 82);
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a frame
    tb_data  = 8'h55;
    tb_div   = 16'd4;
    tb_valid = 1'b1;
    wait_load("midrst");
    tb_valid = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst status", int'({bus1.o_ready, bus1.o_load, bus1.o_ena, bus1.o_busy, bus1.o_done}), 16);
    chk("midrst data", int'(bus1.o_data), 0);
    dn = done_n;
    @(negedge clk);
    rst = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk("midrst no done", done_n - dn, 0);
    chk("midrst ready", int'(m_ready), 1);
    send("after rst", 1'b0, 8'hC6, 16'd2);
    check_frame("after rst", 8'hC6, 2, 22, 19);

    chk("load ena overlap", overlap_n, 0);
    chk("ena while idle", stray_n, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
